alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational datapath ALU. It adds a configurable width and registered results. Multiply and divide run iteratively over WIDTH cycles, signed or unsigned, and return full high/low results (product high half / remainder). Add, subtract, logic and shift operations complete in one cycle. It sits between the register-file read stage and write-back and exchanges operands and results over valid/ready handshakes.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/seq_muldiv.sv | 96 +++++++++
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM state type shared by the
// sequential ALU and its bench.
package alu_pkg;

   // Opcodes
   localparam logic [3:0] OP_PASSB = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_NOT   = 4'b0111;
   localparam logic [3:0] OP_LSR   = 4'b1000;
   localparam logic [3:0] OP_LSL   = 4'b1001;
   localparam logic [3:0] OP_ASR   = 4'b1010;
   localparam logic [3:0] OP_SUB   = 4'b1011;

   // Bit positions inside the 4-bit flags bus
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply and divide go through the iterative core; everything else
   // finishes on the accept edge.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                             input logic n, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_C] = c;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: unsigned iterative multiplier (shift-add) and divider
// (restoring). The first step is taken on the start edge straight from the
// a/b inputs, so WIDTH steps complete WIDTH-1 edges after start. done is
// high for the single cycle in which hi/lo hold the finished result; the
// result registers then keep their value until the next start.
//   multiply: {hi,lo} = a * b
//   divide  : lo = a / b, hi = a % b (undefined for b == 0; caller overrides)
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             running;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
   logic             div_q;

   // step inputs: fresh operands on start, otherwise the working registers
   logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
   logic             cur_div;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shl, div_trial;
   logic [WIDTH-1:0] nx_hi, nx_lo;

   assign done = running && (count == LAST);
   assign hi   = hi_q;
   assign lo   = lo_q;

   // One multiply or divide step on the current working values
   always_comb begin
      cur_hi    = start ? '0     : hi_q;
      cur_lo    = start ? a      : lo_q;
      cur_m     = start ? b      : mcand_q;
      cur_div   = start ? is_div : div_q;
      mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_m} : '0);
      div_shl   = {cur_hi, cur_lo[WIDTH-1]};
      div_trial = div_shl - {1'b0, cur_m};
      nx_hi     = '0;
      nx_lo     = '0;
      if (cur_div) begin
         // bit WIDTH of the trial difference is the borrow: restore on borrow
         if (!div_trial[WIDTH]) begin
            nx_hi = div_trial[WIDTH-1:0];
            nx_lo = {cur_lo[WIDTH-2:0], 1'b1};
         end else begin
            nx_hi = div_shl[WIDTH-1:0];
            nx_lo = {cur_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         nx_hi = mul_sum[WIDTH:1];
         nx_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
      end
   end

   // Working registers and iteration counter
   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         count   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         div_q   <= 1'b0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
         hi_q    <= nx_hi;
         lo_q    <= nx_lo;
         mcand_q <= b;
         div_q   <= is_div;
      end else if (running) begin
         if (done) begin
            running <= 1'b0;
            count   <= '0;
         end else begin
            hi_q  <= nx_hi;
            lo_q  <= nx_lo;
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results. Single-cycle ops land in
// the result registers on the accept edge; multiply/divide run through
// seq_muldiv on operand magnitudes and get their signs and special cases
// fixed up on the edge that moves BUSY -> DONE.
//
// Handshake: an operation is taken on any edge where in_valid && in_ready
// (in_ready only in IDLE); a result is retired on any edge where
// out_valid && out_ready (out_valid only in DONE). Y, Y_hi and flags do not
// change while a result waits. Accept and retire never share a cycle.
//
// The FSM state is kept in the signal 'state' (type state_t) for probing.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_hi,
   output logic [3:0]       flags
);

   localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state, state_nx;

   logic accept, start_md;

   // single-cycle datapath
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   sh;
   logic             shift_big;
   logic [WIDTH-1:0] sc_y;
   logic             sc_c, sc_v;
   logic [3:0]       sc_flags;

   // operand magnitudes for the iterative core
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   // context captured on a mul/div accept
   logic             s_is_div, s_sign, s_neg_a, s_neg_b, s_b_zero, s_min_neg1;
   logic [WIDTH-1:0] s_a;

   // iterative core
   logic             md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   // fix-up of the iterative result
   logic [2*WIDTH-1:0] prod, prod_fx;
   logic [WIDTH-1:0]   fx_y, fx_hi;
   logic               fx_v;
   logic [3:0]         fx_flags;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign start_md  = accept && is_iterative(op);

   assign neg_a = sign && A[WIDTH-1];
   assign neg_b = sign && B[WIDTH-1];
   assign mag_a = neg_a ? -A : A;
   assign mag_b = neg_b ? -B : B;

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (start_md),
      .is_div (op == OP_DIV),
      .a      (mag_a),
      .b      (mag_b),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = is_iterative(op) ? BUSY : DONE;
         BUSY: if (md_done) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle result and its C/V; an out-of-range shift amount is
   // judged on the whole of A, not just the low SHW bits
   always_comb begin
      sum       = {1'b0, A} + {1'b0, B};
      diff      = A - B;
      sh        = A[SHW-1:0];
      shift_big = (A >= W_VAL);
      sc_y      = '0;
      sc_c      = 1'b0;
      sc_v      = 1'b0;
      case (op)
         OP_PASSB: sc_y = B;
         OP_ADD: begin
            sc_y = sum[WIDTH-1:0];
            sc_c = sum[WIDTH];
            sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_y = diff;
            sc_c = (A < B);
            sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: sc_y = A & B;
         OP_OR:  sc_y = A | B;
         OP_NOT: sc_y = ~B;
         OP_LSR: sc_y = shift_big ? '0 : (B >> sh);
         OP_LSL: sc_y = shift_big ? '0 : (B << sh);
         OP_ASR: sc_y = shift_big ? {WIDTH{B[WIDTH-1]}} : WIDTH'($signed(B) >>> sh);
         default: sc_y = '0;
      endcase
      sc_flags = pack_flags(sc_c, (sc_y == '0), sc_y[WIDTH-1], sc_v);
   end

   // Sign fix-up and special cases for the iterative result
   always_comb begin
      prod    = {md_hi, md_lo};
      prod_fx = (s_neg_a ^ s_neg_b) ? -prod : prod;
      fx_y    = '0;
      fx_hi   = '0;
      fx_v    = 1'b0;
      if (!s_is_div) begin
         fx_y  = prod_fx[WIDTH-1:0];
         fx_hi = prod_fx[2*WIDTH-1:WIDTH];
         // overflow when the high half is more than an extension of the low
         fx_v  = s_sign ? (fx_hi != {WIDTH{fx_y[WIDTH-1]}}) : (fx_hi != '0);
      end else if (s_b_zero) begin
         fx_y  = '1;
         fx_hi = s_a;
         fx_v  = 1'b1;
      end else if (s_min_neg1) begin
         fx_y  = MIN_VAL;
         fx_hi = '0;
         fx_v  = 1'b1;
      end else begin
         // quotient sign from both operands, remainder follows the dividend
         fx_y  = (s_neg_a ^ s_neg_b) ? -md_lo : md_lo;
         fx_hi = s_neg_a ? -md_hi : md_hi;
      end
      fx_flags = pack_flags(1'b0, (fx_y == '0), fx_y[WIDTH-1], fx_v);
   end

   // Capture signs and special-case conditions with the mul/div operands
   always_ff @(posedge clk) begin
      if (reset) begin
         s_is_div   <= 1'b0;
         s_sign     <= 1'b0;
         s_neg_a    <= 1'b0;
         s_neg_b    <= 1'b0;
         s_b_zero   <= 1'b0;
         s_min_neg1 <= 1'b0;
         s_a        <= '0;
      end else if (start_md) begin
         s_is_div   <= (op == OP_DIV);
         s_sign     <= sign;
         s_neg_a    <= neg_a;
         s_neg_b    <= neg_b;
         s_b_zero   <= (B == '0);
         s_min_neg1 <= sign && (A == MIN_VAL) && (B == '1);
         s_a        <= A;
      end
   end

   // Result registers: written only on a single-cycle accept or the final
   // mul/div cycle, so they hold while a result waits for out_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         Y     <= '0;
         Y_hi  <= '0;
         flags <= 4'b0000;
      end else if (accept && !is_iterative(op)) begin
         Y     <= sc_y;
         Y_hi  <= '0;
         flags <= sc_flags;
      end else if ((state == BUSY) && md_done) begin
         Y     <= fx_y;
         Y_hi  <= fx_hi;
         flags <= fx_flags;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at
// WIDTH=32. Inputs change on the falling edge, outputs are sampled 1 time
// unit after the rising edge. Latency counts rising edges from the accept
// edge (inclusive) to the first edge after which out_valid is seen.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic        sign;
   logic [31:0] A, B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Y, Y_hi;
   logic [3:0]  flags;

   int compared   = 0;
   int mismatched = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sign      (sign),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .Y_hi      (Y_hi),
      .flags     (flags)
   );

   // clock and run-time bound
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one operation, wait for its result, check it, optionally hold it
   // for some cycles with out_ready low, then retire it.
   task automatic run_op(input string tag, input logic [3:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic [31:0] ehi,
                         input logic [3:0] ef, input int elat, input int hold);
      int lat;
      @(negedge clk);
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op       = o;
      sign     = s;
      A        = a;
      B        = b;
      @(posedge clk);
      #1;
      // scramble the inputs: nothing after the accept edge may matter
      in_valid = 1'b0;
      op       = 4'($urandom_range(0, 15));
      sign     = 1'($urandom_range(0, 1));
      A        = $urandom;
      B        = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'(elat));
      check({tag, "/Y"},       Y,        ey);
      check({tag, "/Y_hi"},    Y_hi,     ehi);
      check({tag, "/flags"},   32'(flags), 32'(ef));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "/hold_ready"}, 32'(in_ready),  32'd0);
         check({tag, "/hold_Y"},     Y,              ey);
         check({tag, "/hold_flags"}, 32'(flags),     32'(ef));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "/retired"},  32'(out_valid), 32'd0);
      check({tag, "/reopened"}, 32'(in_ready),  32'd1);
   endtask

   int pulses;

   // directed sequence
   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 4'd0;
      sign      = 1'b0;
      A         = '0;
      B         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/in_ready",  32'(in_ready),  32'd1);
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/Y",         Y,              32'd0);
      check("reset/Y_hi",      Y_hi,           32'd0);
      check("reset/flags",     32'(flags),     32'd0);
      @(negedge clk);
      reset = 1'b0;

      // add / sub with carry, borrow and overflow
      run_op("add_carry", OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0,        32'h0, 4'b1100, 1, 0);
      run_op("add_ovf",   OP_ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 4'b0011, 1, 0);
      run_op("sub_borrow",OP_SUB, 1'b0, 32'd5,        32'd7, 32'hFFFFFFFE, 32'h0, 4'b1010, 1, 0);

      // logic ops, pass-through, unused opcode
      run_op("and",   OP_AND,   1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b0010, 1, 0);
      run_op("or",    OP_OR,    1'b0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 4'b0000, 1, 0);
      run_op("not",   OP_NOT,   1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h0,        32'h0, 4'b0100, 1, 0);
      run_op("passb", OP_PASSB, 1'b0, 32'h1,        32'h0000ABCD, 32'h0000ABCD, 32'h0, 4'b0000, 1, 0);
      run_op("op2",   4'b0010,  1'b1, 32'h5,        32'h9,        32'h0,        32'h0, 4'b0100, 1, 0);
      run_op("op15",  4'b1111,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0, 4'b0100, 1, 0);

      // shifts, including out-of-range amounts judged on all of A
      run_op("lsr4",    OP_LSR, 1'b0, 32'd4,     32'h80000000, 32'h08000000, 32'h0, 4'b0000, 1, 0);
      run_op("asr4",    OP_ASR, 1'b0, 32'd4,     32'h80000000, 32'hF8000000, 32'h0, 4'b0010, 1, 0);
      run_op("asr40",   OP_ASR, 1'b0, 32'd40,    32'h80000000, 32'hFFFFFFFF, 32'h0, 4'b0010, 1, 0);
      run_op("lsl32",   OP_LSL, 1'b0, 32'd32,    32'h1,        32'h0,        32'h0, 4'b0100, 1, 0);
      run_op("lsl31",   OP_LSL, 1'b0, 32'd31,    32'h1,        32'h80000000, 32'h0, 4'b0010, 1, 0);
      run_op("lsl_256", OP_LSL, 1'b0, 32'h100,   32'h1,        32'h0,        32'h0, 4'b0100, 1, 0);
      run_op("lsr_big", OP_LSR, 1'b0, 32'h21,    32'hFFFFFFFF, 32'h0,        32'h0, 4'b0100, 1, 0);

      // multiply
      run_op("smul",    OP_MUL, 1'b1, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0010, 33, 0);
      run_op("umul_2p32", OP_MUL, 1'b0, 32'h10000,  32'h10000,   32'h0,        32'h1,        4'b0101, 33, 0);
      run_op("umul_max", OP_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,      32'hFFFFFFFE, 4'b0001, 33, 0);
      run_op("smul_nn", OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,       32'h0,        4'b0000, 33, 0);

      // divide
      run_op("div0",    OP_DIV, 1'b0, 32'd100,      32'd0,       32'hFFFFFFFF, 32'd100,      4'b0011, 33, 0);
      run_op("sdiv_m7", OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0010, 33, 0);
      run_op("sdiv_7m2",OP_DIV, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,       4'b0010, 33, 0);
      run_op("udiv",    OP_DIV, 1'b0, 32'd100,      32'd7,       32'd14,       32'd2,        4'b0000, 33, 0);
      run_op("sdiv_min",OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,       4'b0011, 33, 0);
      run_op("sdiv0_neg",OP_DIV, 1'b1, 32'hFFFFFFF0, 32'd0,      32'hFFFFFFFF, 32'hFFFFFFF0, 4'b0011, 33, 0);

      // result held for 5 cycles with out_ready low
      run_op("hold_add", OP_ADD, 1'b0, 32'h10, 32'h20, 32'h30, 32'h0, 4'b0000, 1, 5);

      // reset during a multiply: aborted, no result appears
      @(negedge clk);
      in_valid = 1'b1;
      op       = OP_MUL;
      sign     = 1'b0;
      A        = 32'd3;
      B        = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("abort/busy", 32'(in_ready), 32'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort/in_ready",  32'(in_ready),  32'd1);
      check("abort/out_valid", 32'(out_valid), 32'd0);
      check("abort/Y",         Y,              32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      check("abort/no_result", 32'(pulses), 32'd0);
      run_op("after_abort", OP_ADD, 1'b0, 32'd2, 32'd3, 32'd5, 32'h0, 4'b0000, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
